// File: rtl/charge_controller.sv
// Session sequencer for the coin-operated charger: amount entry, confirm,
// timed charge countdown and completion hold, driven by debounced key levels.
module charge_controller #(
    parameter int CLK_HZ        = 50000000,
    parameter int MAX_AMOUNT    = 20,
    parameter int SEC_PER_YUAN  = 2,
    parameter int INPUT_TIMEOUT = 10,
    parameter int DONE_HOLD     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_value,
    input  logic       press_num,
    input  logic       start,
    input  logic       clear,
    input  logic       confirm,
    output logic [1:0] state,
    output logic [6:0] amount,
    output logic [1:0] digit_cnt,
    output logic [7:0] remain_time,
    output logic       charging,
    output logic       input_err
);
    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, INPUT = 2'd1, CHARGE = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [3:0]  key_s1_q, key_s2_q, key_dly_q;   // {press_num, start, clear, confirm}
    logic [3:0]  kv_s1_q, kv_s2_q;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [7:0]  sec_q, sec_d;
    logic [6:0]  amount_q, amount_d;
    logic [1:0]  digit_cnt_q, digit_cnt_d;
    logic [7:0]  remain_q, remain_d;
    logic        charging_q, charging_d;
    logic        input_err_q, input_err_d;

    logic [3:0]  rise;
    logic        ev_num, ev_st, ev_clr, ev_cnf, key_evt;
    logic        tick, in_timeout, done_hold;
    logic [7:0]  candidate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q  <= '0;
            key_s2_q  <= '0;
            key_dly_q <= '0;
            kv_s1_q   <= '0;
            kv_s2_q   <= '0;
        end else begin
            key_s1_q  <= {press_num, start, clear, confirm};
            key_s2_q  <= key_s1_q;
            key_dly_q <= key_s2_q;
            kv_s1_q   <= key_value;
            kv_s2_q   <= kv_s1_q;
        end
    end

    // Only the highest-priority edge acts: clear > confirm > start > digit.
    assign rise    = key_s2_q & ~key_dly_q;
    assign ev_clr  = rise[1];
    assign ev_cnf  = rise[0] & ~rise[1];
    assign ev_st   = rise[2] & ~rise[1] & ~rise[0];
    assign ev_num  = rise[3] & ~|rise[2:0];
    assign key_evt = ev_clr | ev_cnf | ev_num;

    assign tick       = (cyc_q == CW'(CLK_HZ - 1));
    assign in_timeout = tick && (sec_q == 8'(INPUT_TIMEOUT - 1)) && !key_evt;
    assign done_hold  = tick && (sec_q == 8'(DONE_HOLD - 1));
    assign candidate  = {1'b0, amount_q} * 8'd10 + {4'b0, kv_s2_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ev_st) state_d = INPUT;
            INPUT: begin
                if (ev_cnf && amount_q != '0) state_d = CHARGE;
                else if (in_timeout)          state_d = IDLE;
            end
            CHARGE: begin
                if (ev_clr)                           state_d = IDLE;
                else if (tick && remain_q == 8'd1)    state_d = DONE;
            end
            DONE: begin
                if (ev_clr)         state_d = IDLE;
                else if (ev_st)     state_d = INPUT;
                else if (done_hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        amount_d    = amount_q;
        digit_cnt_d = digit_cnt_q;
        remain_d    = remain_q;
        charging_d  = charging_q;
        input_err_d = input_err_q;
        case (state_q)
            IDLE: if (ev_st) begin
                amount_d    = '0;
                digit_cnt_d = '0;
                input_err_d = 1'b0;
            end
            INPUT: begin
                if (ev_clr) begin
                    amount_d    = '0;
                    digit_cnt_d = '0;
                    input_err_d = 1'b0;
                end else if (ev_cnf) begin
                    if (amount_q == '0) input_err_d = 1'b1;
                    else begin
                        remain_d    = 8'(amount_q * SEC_PER_YUAN);
                        input_err_d = 1'b0;
                        charging_d  = 1'b1;
                    end
                end else if (ev_num) begin
                    if (kv_s2_q > 4'd9) input_err_d = 1'b1;
                    else if (digit_cnt_q == 2'd0) begin
                        amount_d    = {3'b0, kv_s2_q};
                        digit_cnt_d = 2'd1;
                    end else if (digit_cnt_q == 2'd1) begin
                        if (candidate <= 8'(MAX_AMOUNT)) begin
                            amount_d    = candidate[6:0];
                            digit_cnt_d = 2'd2;
                            input_err_d = 1'b0;
                        end else input_err_d = 1'b1;
                    end else input_err_d = 1'b1;
                end else if (in_timeout) begin
                    amount_d    = '0;
                    digit_cnt_d = '0;
                    input_err_d = 1'b0;
                end
            end
            CHARGE: begin
                if (ev_clr) begin
                    charging_d  = 1'b0;
                    remain_d    = '0;
                    amount_d    = '0;
                    digit_cnt_d = '0;
                end else if (tick && remain_q != '0) begin
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) charging_d = 1'b0;
                end
            end
            DONE: begin
                remain_d   = '0;
                charging_d = 1'b0;
                if (ev_clr) amount_d = '0;
                else if (ev_st) begin
                    amount_d    = '0;
                    digit_cnt_d = '0;
                    input_err_d = 1'b0;
                end else if (done_hold) begin
                    amount_d    = '0;
                    digit_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Timer restarts on every state entry and every key event taken in INPUT.
    always_comb begin
        cyc_d = tick ? '0 : cyc_q + CW'(1);
        sec_d = (tick && sec_q != 8'hFF) ? sec_q + 8'd1 : sec_q;
        if (state_d != state_q || (state_q == INPUT && key_evt)) begin
            cyc_d = '0;
            sec_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q       <= '0;
            sec_q       <= '0;
            amount_q    <= '0;
            digit_cnt_q <= '0;
            remain_q    <= '0;
            charging_q  <= 1'b0;
            input_err_q <= 1'b0;
        end else begin
            cyc_q       <= cyc_d;
            sec_q       <= sec_d;
            amount_q    <= amount_d;
            digit_cnt_q <= digit_cnt_d;
            remain_q    <= remain_d;
            charging_q  <= charging_d;
            input_err_q <= input_err_d;
        end
    end

    assign state       = state_q;
    assign amount      = amount_q;
    assign digit_cnt   = digit_cnt_q;
    assign remain_time = remain_q;
    assign charging    = charging_q;
    assign input_err   = input_err_q;
endmodule

// File: tb/tb_charge_controller.sv
// Directed bench for charge_controller at CLK_HZ=10: expected outputs are
// queued as each step is driven and compared when the DUT has updated.
module tb_charge_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_value = '0;
    logic       press_num = 1'b0, start = 1'b0, clear = 1'b0, confirm = 1'b0;
    logic [1:0] state;
    logic [6:0] amount;
    logic [1:0] digit_cnt;
    logic [7:0] remain_time;
    logic       charging, input_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [6:0] amt;
        logic [1:0] dc;
        logic [7:0] rt;
        logic       chg;
        logic       err;
    } exp_t;
    exp_t sb[$];

    localparam logic [3:0] K_NUM = 4'b1000, K_START = 4'b0100, K_CLR = 4'b0010, K_CNF = 4'b0001;

    charge_controller #(.CLK_HZ(10)) dut (
        .clk(clk), .rst_n(rst_n), .key_value(key_value), .press_num(press_num),
        .start(start), .clear(clear), .confirm(confirm), .state(state),
        .amount(amount), .digit_cnt(digit_cnt), .remain_time(remain_time),
        .charging(charging), .input_err(input_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, got, exp);
        end
    endtask

    task automatic expect_o(input string tag, input logic [1:0] st, input logic [6:0] amt,
                            input logic [1:0] dc, input logic [7:0] rt, input logic chg, input logic err);
        exp_t e;
        e.tag = tag; e.st = st; e.amt = amt; e.dc = dc; e.rt = rt; e.chg = chg; e.err = err;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        chk(e.tag, "state",     8'(state),       8'(e.st));
        chk(e.tag, "amount",    8'(amount),      8'(e.amt));
        chk(e.tag, "digit_cnt", 8'(digit_cnt),   8'(e.dc));
        chk(e.tag, "remain",    remain_time,     e.rt);
        chk(e.tag, "charging",  8'(charging),    8'(e.chg));
        chk(e.tag, "input_err", 8'(input_err),   8'(e.err));
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Low gap, then hold the keys for the three cycles the DUT needs to react.
    task automatic pulse(input logic [3:0] m, input logic [3:0] kv);
        wait_n(2);
        key_value = kv;
        {press_num, start, clear, confirm} = m;
        wait_n(3);
        {press_num, start, clear, confirm} = 4'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wait_n(2);
        expect_o("reset", 2'd0, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        compare();
        rst_n = 1'b1;
        wait_n(2);
    endtask

    initial begin
        wait_n(2);
        do_reset();

        // Basic charge: 15 yuan -> 30 s
        expect_o("idle_cnf", 2'd0, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        pulse(K_CNF, 4'd0); compare();
        expect_o("start", 2'd1, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        pulse(K_START, 4'd0); compare();
        expect_o("dig1", 2'd1, 7'd1, 2'd1, 8'd0, 1'b0, 1'b0);
        pulse(K_NUM, 4'd1); compare();
        expect_o("dig5", 2'd1, 7'd15, 2'd2, 8'd0, 1'b0, 1'b0);
        pulse(K_NUM, 4'd5); compare();
        expect_o("confirm", 2'd2, 7'd15, 2'd2, 8'd30, 1'b1, 1'b0);
        pulse(K_CNF, 4'd0); compare();
        wait_n(9);
        expect_o("pre_tick", 2'd2, 7'd15, 2'd2, 8'd30, 1'b1, 1'b0); compare();
        wait_n(1);
        expect_o("tick1", 2'd2, 7'd15, 2'd2, 8'd29, 1'b1, 1'b0); compare();
        wait_n(289);
        expect_o("last_sec", 2'd2, 7'd15, 2'd2, 8'd1, 1'b1, 1'b0); compare();
        wait_n(1);
        expect_o("done", 2'd3, 7'd15, 2'd2, 8'd0, 1'b0, 1'b0); compare();
        wait_n(49);
        expect_o("done_hold", 2'd3, 7'd15, 2'd2, 8'd0, 1'b0, 1'b0); compare();
        wait_n(1);
        expect_o("done_idle", 2'd0, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0); compare();

        // Limit check
        expect_o("lim_start", 2'd1, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        pulse(K_START, 4'd0); compare();
        expect_o("lim_bad", 2'd1, 7'd0, 2'd0, 8'd0, 1'b0, 1'b1);
        pulse(K_NUM, 4'd12); compare();
        expect_o("lim_2", 2'd1, 7'd2, 2'd1, 8'd0, 1'b0, 1'b1);
        pulse(K_NUM, 4'd2); compare();
        expect_o("lim_25", 2'd1, 7'd2, 2'd1, 8'd0, 1'b0, 1'b1);
        pulse(K_NUM, 4'd5); compare();
        expect_o("lim_20", 2'd1, 7'd20, 2'd2, 8'd0, 1'b0, 1'b0);
        pulse(K_NUM, 4'd0); compare();
        expect_o("lim_3rd", 2'd1, 7'd20, 2'd2, 8'd0, 1'b0, 1'b1);
        pulse(K_NUM, 4'd7); compare();
        do_reset();

        // Empty confirm and clear
        expect_o("ec_start", 2'd1, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        pulse(K_START, 4'd0); compare();
        expect_o("ec_cnf", 2'd1, 7'd0, 2'd0, 8'd0, 1'b0, 1'b1);
        pulse(K_CNF, 4'd0); compare();
        expect_o("ec_dig3", 2'd1, 7'd3, 2'd1, 8'd0, 1'b0, 1'b1);
        pulse(K_NUM, 4'd3); compare();
        expect_o("ec_clr", 2'd1, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        pulse(K_CLR, 4'd0); compare();
        do_reset();

        // Abort after three ticks
        pulse(K_START, 4'd0);
        pulse(K_NUM, 4'd4);
        expect_o("ab_cnf", 2'd2, 7'd4, 2'd1, 8'd8, 1'b1, 1'b0);
        pulse(K_CNF, 4'd0); compare();
        wait_n(30);
        expect_o("ab_3tick", 2'd2, 7'd4, 2'd1, 8'd5, 1'b1, 1'b0); compare();
        expect_o("ab_clr", 2'd0, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        pulse(K_CLR, 4'd0); compare();

        // Abort landing on the same edge as a tick
        pulse(K_START, 4'd0);
        pulse(K_NUM, 4'd4);
        pulse(K_CNF, 4'd0);
        wait_n(5);
        expect_o("ab_tick_clr", 2'd0, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        pulse(K_CLR, 4'd0); compare();

        // Input timeout
        pulse(K_START, 4'd0);
        expect_o("to_dig7", 2'd1, 7'd7, 2'd1, 8'd0, 1'b0, 1'b0);
        pulse(K_NUM, 4'd7); compare();
        wait_n(99);
        expect_o("to_before", 2'd1, 7'd7, 2'd1, 8'd0, 1'b0, 1'b0); compare();
        wait_n(1);
        expect_o("to_idle", 2'd0, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0); compare();

        // Clear beats confirm on the same cycle
        pulse(K_START, 4'd0);
        pulse(K_NUM, 4'd7);
        expect_o("prio", 2'd1, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        pulse(K_CLR | K_CNF, 4'd0); compare();

        // Asynchronous reset in the middle of CHARGE
        pulse(K_NUM, 4'd3);
        expect_o("ar_charge", 2'd2, 7'd3, 2'd1, 8'd6, 1'b1, 1'b0);
        pulse(K_CNF, 4'd0); compare();
        wait_n(4);
        #2 rst_n = 1'b0;
        #1;
        expect_o("async_rst", 2'd0, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0); compare();
        @(negedge clk);
        rst_n = 1'b1;
        wait_n(3);
        expect_o("post_rst", 2'd0, 7'd0, 2'd0, 8'd0, 1'b0, 1'b0); compare();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
